sram_burst_ctrl: RTL and testbench

Parametrised single-port asynchronous-SRAM controller for the DE2-115 camera datapath (IS61WV-class SRAM). It accepts burst read/write commands over a request/ack handshake and generates SRAM strobes with address auto-increment. It pulls write data from a first-word-fall-through source and returns read data through a fixed-latency capture pipeline. It sits between the frame-processing blocks and the SRAM pins and replaces the single-word write/idle access block.

---
 rtl/sram_ctrl_pkg.sv | 20 ++
 rtl/sram_burst_ctrl_if.sv | 32 +++
 rtl/sram_rd_pipe.sv | 44 ++++
 rtl/sram_burst_ctrl.sv | 146 ++++++++++++++
 tb/tb_sram_burst_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the burst SRAM controller.
// State encoding, strobe polarity and bus turnaround length.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_SETUP = 3'd1,
        S_WR_PULSE = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_DRAIN = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic STB_ON  = 1'b0;
    localparam logic STB_OFF = 1'b1;

    // Idle cycles in DONE between a read drain and the next DQ drive.
    localparam int unsigned TURN_CYC = 1;

endpackage

// File: rtl/sram_burst_ctrl_if.sv
// Command, write-data and read-data handshake bundle.
// master = frame-processing requester, slave = controller.
interface sram_burst_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20,
    parameter int LEN_W  = 8
);
    logic                  iReq;
    logic                  iWrite;
    logic [ADDR_W-1:0]     iAddr;
    logic [LEN_W-1:0]      iLen;
    logic [DATA_W/8-1:0]   iBE;
    logic                  oAck;
    logic [DATA_W-1:0]     iWrData;
    logic                  oWrReady;
    logic [DATA_W-1:0]     oRdData;
    logic                  oRdValid;
    logic                  oBusy;
    logic                  oDone;

    modport master (
        output iReq, iWrite, iAddr, iLen, iBE, iWrData,
        input  oAck, oWrReady, oRdData, oRdValid,
        input  oBusy, oDone
    );

    modport slave (
        input  iReq, iWrite, iAddr, iLen, iBE, iWrData,
        output oAck, oWrReady, oRdData, oRdValid,
        output oBusy, oDone
    );
endinterface

// File: rtl/sram_rd_pipe.sv
// Read-latency valid shift register with DQ capture.
// Shared with the dual-port arbiter.
module sram_rd_pipe #(
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iPush,
    input  logic [DATA_W-1:0] iDQ,
    output logic [DATA_W-1:0] oData,
    output logic              oValid,
    output logic              oPending
);
    logic [RD_LAT-1:0] vld_q;
    logic              cap;

    // Capture on the edge that moves a token into the last stage.
    generate
        if (RD_LAT == 1) begin : g_lat1
            assign cap      = iPush;
            assign oPending = 1'b0;
        end else begin : g_latn
            assign cap      = vld_q[RD_LAT-2];
            assign oPending = |vld_q[RD_LAT-2:0];
        end
    endgenerate

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            vld_q <= '0;
            oData <= '0;
        end else begin
            vld_q[0] <= iPush;
            for (int i = 1; i < RD_LAT; i++)
                vld_q[i] <= vld_q[i-1];
            if (cap)
                oData <= iDQ;
        end
    end

    assign oValid = vld_q[RD_LAT-1];

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst read/write controller for an asynchronous single-port SRAM.
// Writes take two cycles per word; reads issue one address per cycle.
module sram_burst_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20,
    parameter int LEN_W  = 8,
    parameter int RD_LAT = 2
) (
    input  logic                iCLK,
    input  logic                iRST,
    sram_burst_ctrl_if.slave    bus,
    output logic [ADDR_W-1:0]   oSRAM_ADDR,
    inout  wire  [DATA_W-1:0]   ioSRAM_DQ,
    output logic                oSRAM_WE_N,
    output logic                oSRAM_OE_N,
    output logic                oSRAM_CE_N,
    output logic [DATA_W/8-1:0] oSRAM_BE_N
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [1:0] TURN_LAST = 2'(TURN_CYC - 1);

    state_t            state, nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W:0]    cnt_q;
    logic [LEN_W-1:0]  len_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wd_q;
    logic [1:0]        turn_q;

    logic ack, wr_pop, issue, adv, last;
    logic pend, wr_ph, rd_ph, dq_oe;
    logic [DATA_W-1:0] rd_data;
    logic rd_vld;

    assign last = (cnt_q == {1'b0, len_q});

    always_comb begin
        nxt    = state;
        ack    = 1'b0;
        wr_pop = 1'b0;
        issue  = 1'b0;
        adv    = 1'b0;
        unique case (state)
            S_IDLE: if (bus.iReq) begin
                ack    = 1'b1;
                wr_pop = bus.iWrite;
                nxt    = bus.iWrite ? S_WR_SETUP : S_RD_ISSUE;
            end
            S_WR_SETUP: nxt = S_WR_PULSE;
            S_WR_PULSE: if (last) begin
                nxt = S_DONE;
            end else begin
                wr_pop = 1'b1;
                adv    = 1'b1;
                nxt    = S_WR_SETUP;
            end
            S_RD_ISSUE: begin
                issue = 1'b1;
                if (last) nxt = S_RD_DRAIN;
                else      adv = 1'b1;
            end
            S_RD_DRAIN: if (!pend) nxt = S_DONE;
            S_DONE: if (turn_q == TURN_LAST) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state  <= S_IDLE;
            addr_q <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
            be_q   <= '0;
            wd_q   <= '0;
            turn_q <= '0;
        end else begin
            state <= nxt;
            if (ack) begin
                addr_q <= bus.iAddr;
                cnt_q  <= '0;
                len_q  <= bus.iLen;
                be_q   <= bus.iBE;
            end else if (adv) begin
                addr_q <= addr_q + 1'b1;
                cnt_q  <= cnt_q + 1'b1;
            end
            if (wr_pop)
                wd_q <= bus.iWrData;
            turn_q <= (state == S_DONE) ? turn_q + 2'd1 : 2'd0;
        end
    end

    assign wr_ph = (state == S_WR_SETUP) || (state == S_WR_PULSE);
    assign rd_ph = (state == S_RD_ISSUE) || (state == S_RD_DRAIN);

    always_comb begin
        oSRAM_WE_N = STB_OFF;
        oSRAM_OE_N = STB_OFF;
        oSRAM_CE_N = STB_OFF;
        oSRAM_BE_N = '1;
        dq_oe      = 1'b0;
        unique case (1'b1)
            wr_ph: begin
                oSRAM_CE_N = STB_ON;
                oSRAM_BE_N = ~be_q;
                dq_oe      = 1'b1;
                if (state == S_WR_PULSE)
                    oSRAM_WE_N = STB_ON;
            end
            rd_ph: begin
                oSRAM_CE_N = STB_ON;
                oSRAM_OE_N = STB_ON;
                oSRAM_BE_N = ~be_q;
            end
            default: ;
        endcase
    end

    assign ioSRAM_DQ  = dq_oe ? wd_q : 'z;
    assign oSRAM_ADDR = addr_q;

    sram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iPush    (issue),
        .iDQ      (ioSRAM_DQ),
        .oData    (rd_data),
        .oValid   (rd_vld),
        .oPending (pend)
    );

    // Mealy handshakes are held off while reset is asserted.
    assign bus.oAck     = ack & ~iRST;
    assign bus.oWrReady = wr_pop & ~iRST;
    assign bus.oRdData  = rd_data;
    assign bus.oRdValid = rd_vld;
    assign bus.oBusy    = (state != S_IDLE);
    assign bus.oDone    = (state == S_DONE) && (turn_q == 2'd0);

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl with a latency-matched SRAM model.
// Inputs change 1 time unit after posedge; monitors sample on negedge.
module tb_sram_burst_ctrl;

    localparam int DW = 16;
    localparam int AW = 20;
    localparam int LW = 8;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sram_burst_ctrl_if #(
        .DATA_W (DW), .ADDR_W (AW), .LEN_W (LW)
    ) bus ();

    wire  [DW-1:0] dq;
    logic [AW-1:0] sa;
    logic          we_n, oe_n, ce_n;
    logic [1:0]    be_n;

    sram_burst_ctrl #(
        .DATA_W (DW), .ADDR_W (AW),
        .LEN_W  (LW), .RD_LAT (RL)
    ) dut (
        .iCLK       (clk),
        .iRST       (rst),
        .bus        (bus),
        .oSRAM_ADDR (sa),
        .ioSRAM_DQ  (dq),
        .oSRAM_WE_N (we_n),
        .oSRAM_OE_N (oe_n),
        .oSRAM_CE_N (ce_n),
        .oSRAM_BE_N (be_n)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // SRAM mirror (low 10 address bits); read data lags address by RL-1.
    logic [15:0] mem [0:1023];
    logic [9:0]  a_d;
    logic        oe_d = 1'b0;

    always @(posedge clk) begin
        a_d  <= sa[9:0];
        oe_d <= !oe_n && !ce_n;
        if (!we_n && !ce_n) begin
            if (!be_n[0]) mem[sa[9:0]][7:0]  <= dq[7:0];
            if (!be_n[1]) mem[sa[9:0]][15:8] <= dq[15:8];
        end
    end

    assign dq = oe_d ? mem[a_d] : 'z;

    // First-word-fall-through write source.
    logic [15:0] wq [0:63];
    int pops = 0;
    always @(posedge clk)
        if (bus.oWrReady) pops <= pops + 1;
    always_comb bus.iWrData = wq[pops & 63];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_we = 0, n_wr = 0, n_rd = 0;
    int n_ack = 0, n_done = 0;
    int ack_cyc = 0, done_cyc = 0;
    logic [19:0] we_a  [0:63];
    logic [15:0] we_d  [0:63];
    logic [1:0]  we_be [0:63];
    logic [15:0] rd_d  [0:63];
    int          rd_c  [0:63];

    always @(negedge clk) begin
        chk("we_oe_excl", 32'(we_n | oe_n), 32'd1);
        if (!we_n) begin
            we_a[n_we & 63]  = sa;
            we_d[n_we & 63]  = dq;
            we_be[n_we & 63] = be_n;
            n_we++;
        end
        if (bus.oWrReady) n_wr++;
        if (bus.oRdValid) begin
            rd_d[n_rd & 63] = bus.oRdData;
            rd_c[n_rd & 63] = cyc;
            n_rd++;
        end
        if (bus.oAck) begin
            chk("ack_idle", bus.oBusy, 0);
            ack_cyc = cyc;
            n_ack++;
        end
        if (bus.oDone) begin
            chk("done_busy", bus.oBusy, 1);
            chk("done_strobes", {oe_n, we_n, ce_n}, 3'b111);
            done_cyc = cyc;
            n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w,
                         input logic [19:0] a,
                         input logic [7:0] l,
                         input logic [1:0] be,
                         input string tag);
        int n;
        bus.iReq   = 1'b1;
        bus.iWrite = w;
        bus.iAddr  = a;
        bus.iLen   = l;
        bus.iBE    = be;
        #1;
        n = 0;
        while (!bus.oAck && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_ack"}, bus.oAck, 1);
        tick();
        bus.iReq = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!bus.oDone && n < 600) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, bus.oDone, 1);
        tick();
    endtask

    logic [15:0] A [0:3];
    logic [15:0] B [0:3];
    logic [19:0] wrap_a [0:3];

    initial begin
        int w0, r0, k0, a1, a2, d0, n;
        A[0] = 16'hA011; A[1] = 16'hA122;
        A[2] = 16'hA233; A[3] = 16'hA344;
        B[0] = 16'hB0B1; B[1] = 16'hB1B2;
        B[2] = 16'hB2B3; B[3] = 16'hB3B4;
        wrap_a[0] = 20'hFFFFE; wrap_a[1] = 20'hFFFFF;
        wrap_a[2] = 20'h00000; wrap_a[3] = 20'h00001;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 64; i++) wq[i] = '0;
        bus.iReq = 0; bus.iWrite = 0; bus.iAddr = '0;
        bus.iLen = '0; bus.iBE = '0;
        rst = 1'b1;

        // Reset state, with a request pending that must not be acked.
        repeat (2) tick();
        bus.iReq = 1'b1;
        #1;
        chk("rst_ack", bus.oAck, 0);
        chk("rst_wrrdy", bus.oWrReady, 0);
        chk("rst_busy", bus.oBusy, 0);
        chk("rst_done", bus.oDone, 0);
        chk("rst_rdvld", bus.oRdValid, 0);
        chk("rst_rddata", bus.oRdData, 0);
        chk("rst_addr", sa, 0);
        chk("rst_strobes", {we_n, oe_n, ce_n}, 3'b111);
        chk("rst_be_n", be_n, 2'b11);
        bus.iReq = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Reset in the middle of a write pulse.
        for (int i = 0; i < 6; i++)
            wq[(pops + i) & 63] = 16'h5500 + 16'(i);
        issue(1'b1, 20'h00300, 8'd5, 2'b11, "abort");
        n = 0;
        while (we_n && n < 20) begin
            tick();
            n++;
        end
        chk("abort_we_seen", we_n, 0);
        d0 = n_done;
        rst = 1'b1;
        #1;
        chk("abort_we_async", we_n, 1);
        chk("abort_ce_async", ce_n, 1);
        chk("abort_busy", bus.oBusy, 0);
        tick();
        tick();
        chk("abort_no_done", n_done, d0);
        rst = 1'b0;
        tick();

        // Four-word write at 0x100.
        for (int i = 0; i < 4; i++)
            wq[(pops + i) & 63] = A[i];
        w0 = n_we;
        r0 = n_wr;
        issue(1'b1, 20'h00100, 8'd3, 2'b11, "wr");
        wait_done("wr");
        chk("wr_done_lat", done_cyc - ack_cyc, 9);
        chk("wr_we_pulses", n_we - w0, 4);
        chk("wr_ready_cnt", n_wr - r0, 4);
        for (int i = 0; i < 4; i++) begin
            chk("wr_addr", we_a[(w0 + i) & 63], 20'h00100 + 20'(i));
            chk("wr_dq", we_d[(w0 + i) & 63], A[i]);
            chk("wr_be_n", we_be[(w0 + i) & 63], 2'b00);
        end

        // Read back the same four words.
        r0 = n_rd;
        issue(1'b0, 20'h00100, 8'd3, 2'b11, "rd");
        wait_done("rd");
        chk("rd_count", n_rd - r0, 4);
        chk("rd_first_lat", rd_c[r0 & 63] - ack_cyc, 3);
        chk("rd_done_lat", done_cyc - ack_cyc, 7);
        for (int i = 0; i < 4; i++) begin
            chk("rd_data", rd_d[(r0 + i) & 63], A[i]);
            chk("rd_no_gap", rd_c[(r0 + i) & 63] - rd_c[r0 & 63], i);
        end

        // Write across the top of the address space.
        for (int i = 0; i < 4; i++)
            wq[(pops + i) & 63] = B[i];
        w0 = n_we;
        issue(1'b1, 20'hFFFFE, 8'd3, 2'b11, "wrap");
        wait_done("wrap");
        chk("wrap_pulses", n_we - w0, 4);
        for (int i = 0; i < 4; i++)
            chk("wrap_addr", we_a[(w0 + i) & 63], wrap_a[i]);

        // Request held through a read, then a write back-to-back.
        wq[pops & 63] = 16'h1234;
        k0 = n_ack;
        r0 = n_rd;
        bus.iReq   = 1'b1;
        bus.iWrite = 1'b0;
        bus.iAddr  = 20'hFFFFE;
        bus.iLen   = 8'd3;
        bus.iBE    = 2'b11;
        #1;
        n = 0;
        while (!bus.oAck && n < 100) begin
            tick();
            n++;
        end
        chk("b2b_ack1", bus.oAck, 1);
        tick();
        a1 = ack_cyc;
        bus.iWrite = 1'b1;
        bus.iAddr  = 20'h00200;
        bus.iLen   = 8'd0;
        n = 0;
        while (!bus.oAck && n < 50) begin
            tick();
            n++;
        end
        chk("b2b_ack2", bus.oAck, 1);
        tick();
        bus.iReq = 1'b0;
        a2 = ack_cyc;
        chk("b2b_gap", a2 - a1, 8);
        chk("b2b_acks", n_ack - k0, 2);
        chk("b2b_turn", a2 - done_cyc, 1);
        wait_done("b2b_wr");
        chk("b2b_wr_lat", done_cyc - a2, 3);
        chk("b2b_rd_cnt", n_rd - r0, 4);
        for (int i = 0; i < 4; i++)
            chk("b2b_rd_data", rd_d[(r0 + i) & 63], B[i]);

        // Upper-byte-only write, then full read.
        wq[pops & 63] = 16'hABCD;
        w0 = n_we;
        issue(1'b1, 20'h00200, 8'd0, 2'b10, "be");
        wait_done("be");
        chk("be_pulses", n_we - w0, 1);
        chk("be_n_wr", we_be[w0 & 63], 2'b01);
        r0 = n_rd;
        issue(1'b0, 20'h00200, 8'd0, 2'b11, "berd");
        wait_done("berd");
        chk("berd_count", n_rd - r0, 1);
        chk("berd_data", rd_d[r0 & 63], 16'hAB34);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
